rdmem_backend: RTL and testbench
================================

# rdmem_backend

Memory-side responder that consumes the read-request stream issued by the read-memory front end (16-bit address, valid/ready) and returns 32-bit read data on a valid/ready response channel. It holds a synchronous word array with a configurable read-pipeline latency, preserves request order, and uses an outstanding-request credit counter so no response is ever dropped under downstream backpressure. A side write port loads array contents for initialisation and test.

## Interface
- `ADDR_W`, default 16: request address width.
- `DATA_W`, default 32: data word width.
- `DEPTH_LOG2`, default 10: array holds 2^DEPTH_LOG2 words; address bits above this are ignored.
- `LATENCY`, default 2: cycles from request accept to data entering the response buffer; legal range 1..8.
- `RESP_DEPTH`, default 4: response buffer entries and maximum outstanding requests; legal range ≥ 2.

Ports:
- `i_clk`  in  1  sole clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_req_valid`  in  1  request valid (maps to `mem_req.valid`).
- `o_req_ready`  out  1  request accepted when high with valid (maps to `mem_req_ack.ready`).
- `i_req_addr`  in  ADDR_W  word address (maps to `mem_req.addr`).
- `o_resp_valid`  out  1  response valid (maps to `mem_resp.valid`).
- `o_resp_data`  out  DATA_W  read data (maps to `mem_resp.data`).
- `i_resp_ready`  in  1  consumer ready (maps to `mem_data_ack.ready`).
- `i_wr_en`  in  1  array write strobe.
- `i_wr_addr`  in  DEPTH_LOG2  write word address.
- `i_wr_data`  in  DATA_W  write data.
- `o_outstanding`  out  $clog2(RESP_DEPTH+1)  accepted requests not yet returned.

## Operation
- Accept: `i_req_valid & o_req_ready` in a cycle. `o_req_ready = (outstanding < RESP_DEPTH)` from the registered count only; no combinational path from `i_resp_ready` or `i_req_valid` to `o_req_ready`.
- Outstanding counter: +1 on accept, −1 on response handshake (`o_resp_valid & i_resp_ready`), unchanged when both occur in the same cycle. Never exceeds RESP_DEPTH and never underflows.
- Array read: address `i_req_addr[DEPTH_LOG2-1:0]` is sampled on accept; synchronous read, then LATENCY−1 further register stages, each carrying a valid bit. The last stage pushes into the response FIFO.
- Response FIFO: RESP_DEPTH entries; `o_resp_valid` = not empty; `o_resp_data` = head entry. The credit scheme guarantees a push never finds the FIFO full; a push and a pop may occur in the same cycle.
- Ordering: responses return strictly in accept order.
- Writes: `i_wr_en` writes at the clock edge. A read accepted in the same cycle to the same address returns the old data (read-before-write). Array contents are not reset.
- Handshake stability: while `o_resp_valid & !i_resp_ready`, `o_resp_valid` and `o_resp_data` hold.

## Timing
- Reset (asserted, asynchronous): `o_req_ready`=0, `o_resp_valid`=0, `o_resp_data`=0, `o_outstanding`=0; all pipeline valids and FIFO pointers are cleared. `o_req_ready` rises in the first cycle after `i_reset` deasserts.
- Reset mid-operation: all in-flight and buffered responses are discarded; no response for them ever appears.
- Latency: a request accepted in cycle N with the FIFO empty gives `o_resp_valid`=1 in cycle N+LATENCY. There is no bypass path.
- Throughput: one request per cycle is sustained with `i_resp_ready` held high iff RESP_DEPTH ≥ LATENCY+1. Otherwise the accept rate is RESP_DEPTH per (LATENCY+1) cycles.
- Backpressure: with `i_resp_ready` low, exactly RESP_DEPTH requests are accepted, then `o_req_ready`=0. It reasserts one cycle after the first response handshake.

## Test plan
- Load addr 0x005 = 0xDEADBEEF via write port; reset released; request addr 0x0005 at cycle N with resp_ready=1 -> `o_resp_valid` cycle N+2, data 0xDEADBEEF, `o_outstanding` returns to 0.
- Aliasing: request addr 0xFC05 (DEPTH_LOG2=10) -> returns the 0x005 word, 0xDEADBEEF.
- Streaming: addrs 0..15 preloaded with value = addr×3, back-to-back requests, resp_ready=1 -> 16 responses in order 0,3,…,45, one per cycle, `o_req_ready` never drops.
- Backpressure: resp_ready=0, continuous requests -> exactly 4 accepted, `o_req_ready`=0, `o_outstanding`=4; raise resp_ready -> 4 in-order responses, `o_req_ready` back high the cycle after the first pop.
- Same-cycle write/read to addr 0x010 (old 0x11111111, new 0x22222222) -> response 0x11111111; later read -> 0x22222222.
- Assert i_reset with 3 requests in flight -> outputs clear immediately; after release, no stale responses appear and a new request completes normally.

Source files
------------

// File: rtl/rdmem_backend.sv
// rdmem_backend: memory-side read responder. A synchronous word array feeds a
// fixed-latency read pipeline into an in-order response FIFO; an outstanding
// credit counter throttles requests so the FIFO can never overflow.
module rdmem_backend #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic [ADDR_W-1:0]               i_req_addr,
  output logic                            o_resp_valid,
  output logic [DATA_W-1:0]               o_resp_data,
  input  logic                            i_resp_ready,
  input  logic                            i_wr_en,
  input  logic [DEPTH_LOG2-1:0]           i_wr_addr,
  input  logic [DATA_W-1:0]               i_wr_data,
  output logic [$clog2(RESP_DEPTH+1)-1:0] o_outstanding
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [DATA_W-1:0]     mem  [2**DEPTH_LOG2];
  logic [DATA_W-1:0]     fifo [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         fifo_cnt;
  logic [CW-1:0]         out_cnt, out_cnt_next;
  logic                  req_ready_q;
  logic                  accept, pop, push;
  logic [DATA_W-1:0]     push_data;
  logic [DEPTH_LOG2-1:0] req_idx;

  assign req_idx      = i_req_addr[DEPTH_LOG2-1:0];
  assign accept       = i_req_valid & req_ready_q;
  assign pop          = o_resp_valid & i_resp_ready;
  assign o_req_ready  = req_ready_q;
  assign o_outstanding = out_cnt;
  assign o_resp_valid = (fifo_cnt != '0);
  assign o_resp_data  = o_resp_valid ? fifo[rd_ptr] : '0;

  // Address bits above the array size alias onto the low words.
  if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[ADDR_W-1:DEPTH_LOG2];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Side write port; non-blocking update gives read-before-write on collision.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  if (LATENCY == 1) begin : g_lat1
    // The synchronous read register is the FIFO entry itself.
    assign push      = accept;
    assign push_data = mem[req_idx];
  end else begin : g_pipe
    logic [LATENCY-2:0]             stg_v;
    logic [LATENCY-2:0][DATA_W-1:0] stg_d;

    // Stage valids shift in the accept strobe; index 0 is the array read.
    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) stg_v <= '0;
      else         stg_v <= (LATENCY-1)'({stg_v, accept});
    end

    // Stage data; the width cast drops the oldest stage as the new read enters.
    always_ff @(posedge i_clk) begin
      stg_d <= ((LATENCY-1)*DATA_W)'({stg_d, mem[req_idx]});
    end

    assign push      = stg_v[LATENCY-2];
    assign push_data = stg_d[LATENCY-2];
  end

  // Response FIFO storage.
  always_ff @(posedge i_clk) begin
    if (push) fifo[wr_ptr] <= push_data;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Outstanding credit: +1 on accept, -1 on response handshake.
  always_comb begin
    out_cnt_next = out_cnt;
    case ({accept, pop})
      2'b10:   out_cnt_next = out_cnt + 1'b1;
      2'b01:   out_cnt_next = out_cnt - 1'b1;
      default: out_cnt_next = out_cnt;
    endcase
  end

  // Registered credit count and ready, so ready has no input-to-output path.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      out_cnt     <= '0;
      req_ready_q <= 1'b0;
    end else begin
      out_cnt     <= out_cnt_next;
      req_ready_q <= (out_cnt_next < CW'(RESP_DEPTH));
    end
  end

endmodule

// File: tb/tb_rdmem_backend.sv
// tb_rdmem_backend: table-driven directed reads, hand-written corner sequences
// and a randomized phase, all checked against a queue-based reference model.
module tb_rdmem_backend;

  localparam int LAT = 2;
  localparam int RD  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        o_req_ready;
  logic [15:0] req_addr;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        resp_ready;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  o_outstanding;

  rdmem_backend #(
    .ADDR_W(16), .DATA_W(32), .DEPTH_LOG2(10), .LATENCY(LAT), .RESP_DEPTH(RD)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_addr(req_addr),
    .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .i_resp_ready(resp_ready),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_outstanding(o_outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  logic [31:0] mem_m [1024];
  exp_t        exp_q [$];
  logic [31:0] got_q [$];
  int          got_c [$];
  int          cyc;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample handshakes before the edge, advance the model, check after.
  task automatic cycle();
    bit          acc, pop;
    logic [31:0] pdata;
    logic [9:0]  raddr;
    acc   = req_valid && o_req_ready;
    pop   = o_resp_valid && resp_ready;
    pdata = o_resp_data;
    raddr = req_addr[9:0];
    @(posedge clk);
    #1;
    if (pop) begin
      chk("pop_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("resp_data", pdata, exp_q[0].data);
        got_q.push_back(pdata);
        got_c.push_back(cyc);
        void'(exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back('{data: mem_m[raddr], acc: cyc});
    if (wr_en) mem_m[wr_addr] = wr_data;
    cyc++;
    chk("outstanding", 32'(o_outstanding), exp_q.size());
    chk("req_ready", 32'(o_req_ready), 32'(exp_q.size() < RD));
    chk("resp_valid", 32'(o_resp_valid),
        32'(exp_q.size() > 0 && exp_q[0].acc + LAT <= cyc));
  endtask

  // Single request, optionally with a same-cycle write to the same word.
  task automatic single(input logic [15:0] a, input bit we, input logic [31:0] wd,
                        output logic [31:0] d, output int lat);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    wr_en = we; wr_addr = a[9:0]; wr_data = wd;
    cycle();
    req_valid = 1'b0; wr_en = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      cycle();
      lat++;
    end
    d = o_resp_data;
    cycle();
  endtask

  vec_t        tbl [6];
  logic [31:0] d;
  int          lat;
  int          nacc;
  bit          drop;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    tbl[0] = '{addr: 16'h0005, exp_data: 32'hDEADBEEF, exp_lat: 2};
    tbl[1] = '{addr: 16'hFC05, exp_data: 32'hDEADBEEF, exp_lat: 2};
    tbl[2] = '{addr: 16'h0405, exp_data: 32'hDEADBEEF, exp_lat: 2};
    tbl[3] = '{addr: 16'h7C05, exp_data: 32'hDEADBEEF, exp_lat: 2};
    tbl[4] = '{addr: 16'h03FF, exp_data: 32'hCAFEF00D, exp_lat: 2};
    tbl[5] = '{addr: 16'hFFFF, exp_data: 32'hCAFEF00D, exp_lat: 2};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #3;
    chk("rst_req_ready", 32'(o_req_ready), 0);
    chk("rst_resp_valid", 32'(o_resp_valid), 0);
    chk("rst_resp_data", o_resp_data, 0);
    chk("rst_outstanding", 32'(o_outstanding), 0);

    // Load the whole array through the write port while reset is held.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 10'(i);
      wr_data = (i == 5) ? 32'hDEADBEEF : (i == 1023) ? 32'hCAFEF00D : $urandom;
      mem_m[i] = wr_data;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    chk("ready_in_reset", 32'(o_req_ready), 0);
    rst = 1'b0;
    cycle();
    chk("ready_after_release", 32'(o_req_ready), 1);

    // Directed single reads, including high-address aliasing.
    for (int i = 0; i < 6; i++) begin
      single(tbl[i].addr, 1'b0, '0, d, lat);
      chk("tbl_data", d, tbl[i].exp_data);
      chk("tbl_latency", lat, tbl[i].exp_lat);
      chk("tbl_outstanding", 32'(o_outstanding), 0);
    end

    // Streaming: addr i holds 3*i, back-to-back requests.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 10'(i); wr_data = 32'(i * 3);
      cycle();
    end
    wr_en = 1'b0;
    got_q.delete(); got_c.delete(); drop = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 16'(i);
      if (!o_req_ready) drop = 1'b1;
      cycle();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("stream_ready_drop", 32'(drop), 0);
    chk("stream_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      chk("stream_data", got_q[i], 32'(i * 3));
      chk("stream_spacing", got_c[i], got_c[0] + i);
    end

    // Backpressure: only RESP_DEPTH accepts while the consumer stalls.
    got_q.delete(); got_c.delete(); nacc = 0; resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 16'(i);
      if (o_req_ready) nacc++;
      cycle();
    end
    req_valid = 1'b0;
    chk("bp_accepts", nacc, 4);
    chk("bp_ready_low", 32'(o_req_ready), 0);
    chk("bp_outstanding", 32'(o_outstanding), 4);
    resp_ready = 1'b1;
    cycle();
    chk("bp_ready_reassert", 32'(o_req_ready), 1);
    for (int i = 0; i < 6; i++) cycle();
    chk("bp_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_data", got_q[i], 32'(i * 3));

    // Same-cycle write and read: old data returned, new data afterwards.
    wr_en = 1'b1; wr_addr = 10'h010; wr_data = 32'h11111111;
    cycle();
    wr_en = 1'b0;
    single(16'h0010, 1'b1, 32'h22222222, d, lat);
    chk("rbw_old", d, 32'h11111111);
    single(16'h0010, 1'b0, '0, d, lat);
    chk("rbw_new", d, 32'h22222222);

    // Reset with three requests in flight.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 16'h03FF;
      cycle();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(o_req_ready), 0);
    chk("midrst_resp_valid", 32'(o_resp_valid), 0);
    chk("midrst_resp_data", o_resp_data, 0);
    chk("midrst_outstanding", 32'(o_outstanding), 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    single(16'h03FF, 1'b0, '0, d, lat);
    chk("postrst_data", d, 32'hCAFEF00D);
    chk("postrst_latency", lat, LAT);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      req_valid  = ($urandom % 4) != 0;
      req_addr   = 16'($urandom);
      resp_ready = ($urandom % 3) != 0;
      wr_en      = ($urandom % 8) == 0;
      wr_addr    = 10'($urandom);
      wr_data    = $urandom;
      cycle();
    end
    req_valid = 1'b0; wr_en = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("rand_drained", 32'(o_outstanding), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
